c499_key_loader: RTL and testbench

//  Serial key-delivery stage directly upstream of the locked c499 SEC netlist.

---
 rtl/c499_lock_pkg.sv | 31 +++
 rtl/c499_key_loader_if.sv | 31 +++
 rtl/c499_key_shreg.sv | 50 +++++
 rtl/c499_key_loader.sv | 131 +++++++++++++
 tb/tb_c499_key_loader.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c499_lock_pkg.sv
// ----------------------------------------------------------------------------
// c499_lock_pkg
// Shared widths, safe key values, loader state encoding and the frame check
// function for the c499 key-delivery path.
// ----------------------------------------------------------------------------
package c499_lock_pkg;

    localparam int KEY_W    = 6;                    // key[5:2]=p[4:1], key[1:0]=x[2:1]
    localparam int CHK_W    = 2;
    localparam int FRAME_W  = KEY_W + CHK_W;        // {key, chk}, MSB first on the wire
    localparam int MAX_FAIL = 3;
    localparam int FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam int CNT_W    = $clog2(FRAME_W + 1);

    localparam logic [3:0] SAFE_P = 4'b0000;
    localparam logic [1:0] SAFE_X = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        ARMED,
        LOCKOUT
    } state_e;

    // chk[1] covers the odd key bits, chk[0] the even key bits.
    function automatic logic [CHK_W-1:0] key_chk(input logic [KEY_W-1:0] key);
        return {key[5] ^ key[3] ^ key[1], key[4] ^ key[2] ^ key[0]};
    endfunction

endpackage

// File: rtl/c499_key_loader_if.sv
// ----------------------------------------------------------------------------
// c499_key_loader_if
// Serial key input and netlist key/status outputs of the c499 key loader.
//   key_sen/key_sdi : shift enable and serial data (driven by master)
//   p/x             : registered mux-select and XOR keys to the netlist
//   key_valid/busy/err/locked, fail_cnt : loader status
// master = key source, slave = loader.
// ----------------------------------------------------------------------------
interface c499_key_loader_if;
    import c499_lock_pkg::*;

    logic              key_sen;
    logic              key_sdi;
    logic [3:0]        p;
    logic [1:0]        x;
    logic              key_valid;
    logic              key_busy;
    logic              key_err;
    logic              key_locked;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output key_sen, key_sdi,
        input  p, x, key_valid, key_busy, key_err, key_locked, fail_cnt
    );

    modport slave (
        input  key_sen, key_sdi,
        output p, x, key_valid, key_busy, key_err, key_locked, fail_cnt
    );
endinterface

// File: rtl/c499_key_shreg.sv
// ----------------------------------------------------------------------------
// c499_key_shreg
// Frame shift register plus sampled-bit counter.
//   clk, rst_n   : clock, async active-low reset
//   i_start      : sample the first frame bit (counter restarts at 1)
//   i_active     : a frame is being shifted in
//   i_sen/i_sdi  : shift enable / serial data
//   o_frame      : shifted frame, first bit received in the MSB
//   o_frame_full : the bit sampled this cycle completes the frame
//   o_abort      : shift enable dropped before the frame completed
// ----------------------------------------------------------------------------
module c499_key_shreg
    import c499_lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_active,
    input  logic               i_sen,
    input  logic               i_sdi,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_full,
    output logic               o_abort
);

    logic [FRAME_W-1:0] r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_take;

    assign w_take = i_start | (i_active & i_sen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_take) begin
            r_data <= {r_data[FRAME_W-2:0], i_sdi};
            r_cnt  <= i_start ? CNT_W'(1) : r_cnt + 1'b1;
        end else if (!i_active) begin
            r_cnt  <= '0;
        end
    end

    // While shifting the count is always below FRAME_W, so a dropped enable
    // is always a short frame.
    assign o_frame      = r_data;
    assign o_frame_full = i_active & i_sen & (r_cnt == CNT_W'(FRAME_W - 1));
    assign o_abort      = i_active & ~i_sen;

endmodule

// File: rtl/c499_key_loader.sv
// ----------------------------------------------------------------------------
// c499_key_loader
// Serial key loader for the locked c499 netlist. Shifts in {key, chk}, checks
// parity and p legality, and drives registered p/x keys. p/x sit at the safe
// value whenever no checked key is committed; MAX_FAIL consecutive bad or
// aborted frames lock the loader until reset.
//   clk, rst_n : clock, async active-low reset
//   bus        : c499_key_loader_if.slave (serial input, keys, status)
// ----------------------------------------------------------------------------
module c499_key_loader
    import c499_lock_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    c499_key_loader_if.slave     bus
);

    state_e             r_state, w_nxt_state;
    logic [3:0]         r_p, w_nxt_p;
    logic [1:0]         r_x, w_nxt_x;
    logic               r_valid, w_nxt_valid;
    logic               r_err, w_nxt_err;
    logic               r_locked, w_nxt_locked;
    logic [FAIL_W-1:0]  r_fail, w_nxt_fail, w_fail_inc;

    logic [FRAME_W-1:0] w_frame;
    logic [KEY_W-1:0]   w_key;
    logic [CHK_W-1:0]   w_chk;
    logic               w_frame_full, w_abort, w_start, w_pass, w_fail;

    assign w_start = bus.key_sen & ((r_state == IDLE) | (r_state == ARMED));

    c499_key_shreg u_shreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (w_start),
        .i_active     (r_state == SHIFT),
        .i_sen        (bus.key_sen),
        .i_sdi        (bus.key_sdi),
        .o_frame      (w_frame),
        .o_frame_full (w_frame_full),
        .o_abort      (w_abort)
    );

    assign w_key  = w_frame[FRAME_W-1:CHK_W];
    assign w_chk  = w_frame[CHK_W-1:0];
    // All-zero and all-one p leave the netlist in a trivially attackable mode.
    assign w_pass = (w_chk == key_chk(w_key)) &&
                    (w_key[5:2] != 4'b0000) && (w_key[5:2] != 4'b1111);

    assign w_fail_inc = (r_fail == FAIL_W'(MAX_FAIL)) ? r_fail : r_fail + 1'b1;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_p      = r_p;
        w_nxt_x      = r_x;
        w_nxt_valid  = r_valid;
        w_nxt_err    = 1'b0;
        w_nxt_locked = r_locked;
        w_nxt_fail   = r_fail;
        w_fail       = 1'b0;
        case (r_state)
            IDLE, ARMED: if (bus.key_sen) w_nxt_state = SHIFT;
            SHIFT: begin
                if (w_frame_full)  w_nxt_state = CHECK;
                else if (w_abort)  w_fail      = 1'b1;
            end
            CHECK: begin
                if (w_pass) begin
                    w_nxt_p     = w_key[5:2];
                    w_nxt_x     = w_key[1:0];
                    w_nxt_valid = 1'b1;
                    w_nxt_fail  = '0;
                    w_nxt_state = ARMED;
                end else begin
                    w_fail = 1'b1;
                end
            end
            LOCKOUT: begin
                w_nxt_p      = SAFE_P;
                w_nxt_x      = SAFE_X;
                w_nxt_valid  = 1'b0;
                w_nxt_locked = 1'b1;
            end
            default: w_nxt_state = IDLE;
        endcase
        // A failed reload drops the old key on the same edge: fail-secure.
        if (w_fail) begin
            w_nxt_err   = 1'b1;
            w_nxt_valid = 1'b0;
            w_nxt_p     = SAFE_P;
            w_nxt_x     = SAFE_X;
            w_nxt_fail  = w_fail_inc;
            if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
                w_nxt_state  = LOCKOUT;
                w_nxt_locked = 1'b1;
            end else begin
                w_nxt_state  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_p      <= SAFE_P;
            r_x      <= SAFE_X;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
            r_fail   <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_p      <= w_nxt_p;
            r_x      <= w_nxt_x;
            r_valid  <= w_nxt_valid;
            r_err    <= w_nxt_err;
            r_locked <= w_nxt_locked;
            r_fail   <= w_nxt_fail;
        end
    end

    assign bus.p          = r_p;
    assign bus.x          = r_x;
    assign bus.key_valid  = r_valid;
    assign bus.key_err    = r_err;
    assign bus.key_locked = r_locked;
    assign bus.fail_cnt   = r_fail;
    assign bus.key_busy   = (r_state == SHIFT) | (r_state == CHECK);

endmodule

// File: tb/tb_c499_key_loader.sv
// ----------------------------------------------------------------------------
// tb_c499_key_loader
// Self-checking bench for c499_key_loader. A behavioural model tracks the
// committed key, failure count and lockout from the frame rules alone.
// Outputs are compared as one packed vector
//   {p, x, key_valid, key_err, key_locked, key_busy, fail_cnt}.
// ----------------------------------------------------------------------------
module tb_c499_key_loader;
    import c499_lock_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    c499_key_loader_if bus();

    c499_key_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_p;
    logic [1:0] m_x;
    logic       m_valid;
    logic       m_locked;
    logic [1:0] m_fails;

    logic [11:0] obs;
    assign obs = {bus.p, bus.x, bus.key_valid, bus.key_err, bus.key_locked,
                  bus.key_busy, bus.fail_cnt};

    function automatic logic [11:0] exp_vec(input logic err, input logic busy);
        return {m_p, m_x, m_valid, err, m_locked, busy, m_fails};
    endfunction

    function automatic logic odd(input logic [2:0] b);
        return ($countones(b) % 2) == 1;
    endfunction

    // Build a frame with correct check bits for a 6-bit key.
    function automatic logic [7:0] mk_frame(input logic [5:0] k);
        return {k, odd({k[5], k[3], k[1]}), odd({k[4], k[2], k[0]})};
    endfunction

    function automatic logic legal(input logic [7:0] f);
        logic [5:0] k;
        k = f[7:2];
        return (f[1] == odd({k[5], k[3], k[1]})) && (f[0] == odd({k[4], k[2], k[0]})) &&
               (k[5:2] != 4'h0) && (k[5:2] != 4'hF);
    endfunction

    task automatic model_reset();
        m_p = 4'h0; m_x = 2'h0; m_valid = 1'b0; m_locked = 1'b0; m_fails = 2'd0;
    endtask

    task automatic model_apply(input logic [7:0] f, input int n, output logic err);
        err = 1'b0;
        if (m_locked || n == 0) return;
        if (n == 8 && legal(f)) begin
            m_p = f[7:4]; m_x = f[3:2]; m_valid = 1'b1; m_fails = 2'd0;
        end else begin
            err = 1'b1; m_valid = 1'b0; m_p = 4'h0; m_x = 2'h0;
            if (m_fails != 2'd3) m_fails = m_fails + 2'd1;
            if (m_fails == 2'd3) m_locked = 1'b1;
        end
    endtask

    // Starts and ends on a falling edge; key_sen drops after n bits.
    task automatic drive_bits(input logic [7:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_sen = 1'b1;
            bus.key_sdi = f[7-i];
            @(negedge clk);
        end
        bus.key_sen = 1'b0;
        bus.key_sdi = 1'b0;
    endtask

    // Drive a frame and advance to the edge where its outcome is visible.
    task automatic frame(input logic [7:0] f, input int n, output logic err);
        drive_bits(f, n);
        @(negedge clk);
        model_apply(f, n, err);
    endtask

    task automatic do_reset();
        bus.key_sen = 1'b0;
        bus.key_sdi = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 12'h000) begin
            $display("FAIL reset_state: got %b want %b", obs, 12'h000); errors++;
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_vec(1'b0, 1'b0)) begin
            $display("FAIL idle_after_reset: got %b want %b", obs, exp_vec(1'b0, 1'b0)); errors++;
        end
    endtask

    task automatic test_good_key();
        logic e;
        do_reset();
        frame(8'b01100011, 8, e);
        checks++;
        if ({bus.p, bus.x, bus.key_valid, bus.fail_cnt} !== {4'b0110, 2'b00, 1'b1, 2'd0}) begin
            $display("FAIL good_key: got p=%b x=%b v=%b f=%0d want p=0110 x=00 v=1 f=0",
                     bus.p, bus.x, bus.key_valid, bus.fail_cnt); errors++;
        end
        checks++;
        if (obs !== exp_vec(e, 1'b0)) begin
            $display("FAIL good_key_model: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
    endtask

    task automatic test_bad_parity();
        logic e;
        do_reset();
        frame(8'b01100010, 8, e);
        checks++;
        if (obs !== {4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1}) begin
            $display("FAIL bad_parity: got %b want %b", obs, {4'b0000, 2'b00, 4'b0100, 2'd1}); errors++;
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_vec(1'b0, 1'b0)) begin
            $display("FAIL bad_parity_err_clear: got %b want %b", obs, exp_vec(1'b0, 1'b0)); errors++;
        end
    endtask

    task automatic test_illegal_p();
        logic e;
        do_reset();
        frame(mk_frame(6'b000001), 8, e);
        checks++;
        if (obs !== exp_vec(e, 1'b0) || !e) begin
            $display("FAIL illegal_p_0000: got %b want %b", obs, exp_vec(1'b1, 1'b0)); errors++;
        end
        @(negedge clk);
        frame(mk_frame(6'b111110), 8, e);
        checks++;
        if (bus.fail_cnt !== 2'd2 || bus.key_err !== 1'b1 || obs !== exp_vec(e, 1'b0)) begin
            $display("FAIL illegal_p_1111: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
    endtask

    task automatic test_abort_lockout();
        logic e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            frame(8'b01100011, 5, e);
            checks++;
            if (obs !== exp_vec(e, 1'b0) || !e) begin
                $display("FAIL abort_%0d: got %b want %b", k, obs, exp_vec(1'b1, 1'b0)); errors++;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.key_locked !== 1'b1 || bus.fail_cnt !== 2'd3) begin
            $display("FAIL lockout_flag: got locked=%b f=%0d want locked=1 f=3",
                     bus.key_locked, bus.fail_cnt); errors++;
        end
        drive_bits(8'b01100011, 8);
        checks++;
        if (obs !== exp_vec(1'b0, 1'b0)) begin
            $display("FAIL lockout_not_busy: got %b want %b", obs, exp_vec(1'b0, 1'b0)); errors++;
        end
        @(negedge clk);
        model_apply(8'b01100011, 8, e);
        checks++;
        if (obs !== exp_vec(e, 1'b0) || bus.key_valid !== 1'b0) begin
            $display("FAIL lockout_ignores_frame: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
    endtask

    task automatic test_reload();
        logic e;
        logic [7:0] f;
        do_reset();
        frame(8'b01100011, 8, e);
        @(negedge clk);
        f = mk_frame(6'b100111);
        drive_bits(f, 8);
        // In CHECK: old key still driven
        checks++;
        if (obs !== exp_vec(1'b0, 1'b1) || bus.p !== 4'b0110) begin
            $display("FAIL reload_hold: got %b want %b", obs, exp_vec(1'b0, 1'b1)); errors++;
        end
        @(negedge clk);
        model_apply(f, 8, e);
        checks++;
        if ({bus.p, bus.x} !== 6'b1001_11 || obs !== exp_vec(e, 1'b0)) begin
            $display("FAIL reload_commit: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
        @(negedge clk);
        frame(8'b10011111, 8, e);
        checks++;
        if ({bus.p, bus.x, bus.key_valid} !== 7'b0000_00_0 || obs !== exp_vec(e, 1'b0)) begin
            $display("FAIL reload_bad_safe: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
        @(negedge clk);
        frame(8'b01100011, 3, e);
        checks++;
        if (obs !== exp_vec(e, 1'b0) || bus.fail_cnt !== 2'd2) begin
            $display("FAIL abort_counts_up: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
    endtask

    task automatic test_reset_midframe();
        logic e;
        do_reset();
        frame(8'b01100011, 8, e);
        @(negedge clk);
        drive_bits(8'b10011100, 4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 12'h000) begin
            $display("FAIL async_reset: got %b want %b", obs, 12'h000); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame(mk_frame(6'b100111), 8, e);
        checks++;
        if (obs !== exp_vec(e, 1'b0) || bus.key_valid !== 1'b1) begin
            $display("FAIL commit_after_reset: got %b want %b", obs, exp_vec(e, 1'b0)); errors++;
        end
    endtask

    task automatic test_random();
        logic e;
        logic [7:0] f;
        int n, r;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            if (m_locked) do_reset();
            r = $urandom_range(0, 9);
            f = (r < 5) ? mk_frame(6'($urandom)) : 8'($urandom);
            n = (r == 9) ? $urandom_range(1, 7) : 8;
            frame(f, n, e);
            checks++;
            if (obs !== exp_vec(e, 1'b0)) begin
                $display("FAIL rand_%0d f=%b n=%0d: got %b want %b", it, f, n, obs, exp_vec(e, 1'b0));
                errors++;
            end
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(1'b0, 1'b0)) begin
                $display("FAIL rand_settle_%0d: got %b want %b", it, obs, exp_vec(1'b0, 1'b0));
                errors++;
            end
        end
    endtask

    initial begin
        bus.key_sen = 1'b0;
        bus.key_sdi = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_good_key();
        test_bad_parity();
        test_illegal_p();
        test_abort_lockout();
        test_reload();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
